multiword_add_ctrl: RTL and testbench
=====================================

MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 4, bits per adder slice.
REQ-002 Parameter WORDS SHALL be: WORDS, default 4, slices per operand; legal range >= 1; total operand width N = WIDTH*WORDS.
REQ-003 Port SHALL be: clk  input  1  rising-edge clock, the only clock.
REQ-004 Port SHALL be: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port SHALL be: in_valid  input  1  request carries a valid operand set.
REQ-006 Port SHALL be: in_ready  output  1  block can accept a request.
REQ-007 Port SHALL be: a  input  N  operand A.
REQ-008 Port SHALL be: b  input  N  operand B.
REQ-009 Port SHALL be: cin  input  1  carry-in to slice 0.
REQ-010 Port SHALL be: out_valid  output  1  result is present.
REQ-011 Port SHALL be: out_ready  input  1  consumer accepts the result.
REQ-012 Port SHALL be: sum  output  N  registered result.
REQ-013 Port SHALL be: cout  output  1  registered carry-out of slice WORDS-1.
REQ-014 Port SHALL be: busy  output  1  high in RUN or DONE.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 IDLE behaviour SHALL be: in_ready=1 and out_valid=0.
REQ-017 Acceptance in IDLE SHALL occur on in_valid=1 at a clk edge: capture a, b and cin, clear slice index idx to 0, load the carry register with cin, and go to RUN.
REQ-018 Each RUN cycle SHALL compute one slice with one WIDTH-bit adder: sum[idx*WIDTH +: WIDTH] <= a_slice + b_slice + carry, carry <= slice carry-out, idx <= idx+1.
REQ-019 When idx = WORDS-1 in RUN, the FSM SHALL write the final slice, set cout to that slice's carry-out, and go to DONE.
REQ-020 Latency SHALL be exactly WORDS cycles: out_valid rises WORDS clk edges after the acceptance edge (WORDS=1 gives 1 cycle).
REQ-021 DONE behaviour SHALL be: out_valid=1, with sum and cout held stable until out_ready=1 at a clk edge, then go to IDLE.
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored, with no capture and no queuing.
REQ-023 No same-cycle accept SHALL occur on the DONE->IDLE edge; a new request is accepted no earlier than the following edge, giving a minimum period of WORDS+2 cycles.
REQ-024 Captured operands SHALL be used for the whole operation; changes on a, b or cin after acceptance SHALL have no effect.
REQ-025 Arithmetic SHALL be unsigned modulo 2^N; {cout,sum} SHALL equal a+b+cin exactly.
REQ-026 idx SHALL be $clog2(WORDS) bits wide (minimum 1) and SHALL never exceed WORDS-1.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 Asserting rst_n=0 SHALL, asynchronously and in any state including mid-RUN, force state=IDLE, idx=0, carry=0, sum=0, cout=0 and out_valid=0.
REQ-029 in_ready SHALL be 1 and busy SHALL be 0 while in reset and after reset release.
REQ-030 A partially computed operation SHALL be discarded on reset, with no result emitted.

Structure
REQ-031 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in shared package adder_ctrl_pkg.
REQ-032 The slice adder SHALL be one instance of ripple_adder_prim with WIDTH=WIDTH, driven by the captured slice selected by idx and by the carry register.
REQ-033 All block outputs SHALL be driven directly from registers or from the state decode.

Verification (WIDTH=4, WORDS=4)
REQ-034 Basic add: a=16'h1234, b=16'h4321, cin=0 -> sum=16'h5555, cout=0, out_valid exactly 4 edges after acceptance.
REQ-035 Full ripple: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1; a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> sum and cout stable, in_ready=0, new operands not captured; out_ready=1 -> IDLE, then accepted next edge.
REQ-037 Operand change: change a and b on the cycle after acceptance -> result still matches the captured values.
REQ-038 Reset mid-RUN: assert rst_n=0 at idx=2 -> sum=0, cout=0, out_valid=0, in_ready=1 immediately; after release, a=16'h0F0F, b=16'h00F1 -> sum=16'h1000, cout=0.
REQ-039 Random: 1000 random a, b and cin values with random out_ready stalls -> every {cout,sum} equals a+b+cin, and none are dropped or duplicated.

Source files
------------

// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the multi-word serial adder controller.
package adder_ctrl_pkg;

  // Controller states; encodings are shared with other blocks that decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } add_state_e;

  // Width of a slice index; never narrower than one bit so WORDS=1 still works.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage : adder_ctrl_pkg

// File: rtl/ripple_adder_prim.sv
// One WIDTH-bit ripple-carry adder slice, built as a chain of full adders.
module ripple_adder_prim #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] carry;

  // Ripple the carry bit by bit from the slice carry-in.
  // NOTE: every variable written in always_comb is assigned before any branch
  // or loop reads it, so no path leaves it holding a value and no latch is inferred.
  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = carry[WIDTH];

endmodule : ripple_adder_prim

// File: rtl/multiword_add_ctrl.sv
// Multi-word adder: adds two WIDTH*WORDS-bit operands one WIDTH-bit slice per
// clock using a single slice adder, with valid/ready handshakes on both sides.
module multiword_add_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   busy
);

  localparam int N     = WIDTH * WORDS;
  localparam int IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  add_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [N-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [N-1:0]     a_q, b_q;
  logic             capture;

  logic [WIDTH-1:0] a_slice, b_slice, slice_sum;
  logic             slice_cout;

  // Captured operand slice selected by the current index.
  assign a_slice = a_q[int'(idx_q)*WIDTH +: WIDTH];
  assign b_slice = b_q[int'(idx_q)*WIDTH +: WIDTH];

  ripple_adder_prim #(
    .WIDTH (WIDTH)
  ) u_slice_add (
    .a_i    (a_slice),
    .b_i    (b_slice),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // Next-state and datapath update: accept in IDLE, one slice per RUN cycle,
  // hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          idx_d   = '0;
          carry_d = cin;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[int'(idx_q)*WIDTH +: WIDTH] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and result registers; reset abandons any operation in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Operand capture on acceptance; held unchanged for the whole operation.
  // NOTE: these are pure data registers, only read after a capture has loaded
  // them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule : multiword_add_ctrl

// File: tb/tb_multiword_add_ctrl.sv
// Directed and random checks of multiword_add_ctrl at WIDTH=4, WORDS=4.
module tb_multiword_add_ctrl;

  localparam int WIDTH = 4;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         busy;

  int total = 0;
  int bad   = 0;

  multiword_add_ctrl #(
    .WIDTH (WIDTH),
    .WORDS (WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set, wait for the result, check it, then hand it off
  // after `stall` extra DONE cycles.
  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic ci,
                        input int stall, input bit scramble, input string tag);
    logic [N:0] expv;
    int         n;
    expv = {1'b0, av} + {1'b0, bv} + (N+1)'(ci);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check({tag, " ready_timeout"}, 64'(in_ready), 64'd1);
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (scramble) begin
      a = ~av; b = ~bv; cin = ~ci;
    end
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(WORDS));
    check({tag, " result"}, 64'({cout, sum}), 64'(expv));
    repeat (stall) begin
      tick();
      if ({cout, sum} !== expv) check({tag, " stall_hold"}, 64'({cout, sum}), 64'(expv));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " released"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int         n;
    logic [N-1:0] ra, rb;
    logic         rc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12;
    // Reset values while reset is held.
    check("rst in_ready",  64'(in_ready),  64'd1);
    check("rst busy",      64'(busy),      64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst sum_cout",  64'({cout, sum}), 64'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst in_ready", 64'(in_ready), 64'd1);
    check("post_rst busy",     64'(busy),     64'd0);

    // out_ready with nothing to deliver has no effect.
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    check("idle out_ready out_valid", 64'(out_valid), 64'd0);
    check("idle out_ready in_ready",  64'(in_ready),  64'd1);

    // Basic add and full-ripple corners.
    run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, "basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "ripple1");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0, "ripple2");

    // Operand change right after acceptance must not alter the result.
    run_op(16'h8001, 16'h7FFF, 1'b0, 0, 1'b1, "opchange");

    // Backpressure: hold DONE with a competing request on the input.
    a = 16'h0F00; b = 16'h00F0; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp latency", 64'(n), 64'd4);
    a = 16'hAAAA; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp hold", 64'({cout, sum}), 64'h0FF1);
      check("bp in_ready", 64'(in_ready), 64'd0);
      check("bp out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp to_idle in_ready", 64'(in_ready), 64'd1);
    check("bp to_idle busy",     64'(busy),     64'd0);
    tick();
    in_valid = 1'b0;
    check("bp accept busy", 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp2 latency", 64'(n), 64'd4);
    check("bp2 result", 64'({cout, sum}), 64'h0BBBB);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of RUN, with slice index at 2.
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrst sum_cout",  64'({cout, sum}), 64'd0);
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready",  64'(in_ready),  64'd1);
    check("midrst busy",      64'(busy),      64'd0);
    #10;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst no_result", 64'(out_valid), 64'd0);
    end
    run_op(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0, "after_rst");

    // Random operands with random consumer stalls.
    for (int i = 0; i < 1000; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rc = 1'($urandom);
      repeat ($urandom_range(0, 1)) tick();
      run_op(ra, rb, rc, $urandom_range(0, 3), 1'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_multiword_add_ctrl
